lru_cache_ctrl: RTL
===================

Name: lru_cache_ctrl

Overview:
- Access-side controller for a single 4-way set, with per-way 2-bit LRU ages.
- Accepts CPU read/write requests and resolves hit or miss.
- On a miss, selects the victim way, writes it back if dirty, fetches the line from memory and fills it.
- Updates the LRU ages on every completed access, placing it upstream of the memory handshake and alongside the existing age-rotation logic.

Parameters:
- TAG_W, 4, tag width.
- DATA_W, 8, line data width (one word per line).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_wr  in  1  1=write, 0=read.
- req_tag  in  TAG_W  request tag.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  request accepted this cycle when req_valid=1.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  completed access was a hit.
- resp_rdata  out  DATA_W  line data after the access.
- mem_req  out  1  memory transaction pending.
- mem_we  out  1  1=writeback, 0=fetch.
- mem_tag  out  TAG_W  memory address (tag).
- mem_wdata  out  DATA_W  writeback data.
- mem_ack  in  1  memory completes the current transaction this cycle.
- mem_rdata  in  DATA_W  fetch data, valid with mem_ack.
- dbg_ages  out  8  {age3,age2,age1,age0}, for verification.

Behaviour:
- Storage per way: valid, dirty, tag[TAG_W], data[DATA_W], age[2].
- Reset (synchronous, active-high):
  - valid=0, dirty=0, tag=0 and data=0 for all ways; ages way0..3 = 0,1,2,3.
  - FSM goes to IDLE.
  - resp_valid=0, resp_hit=0, resp_rdata=0, mem_req=0, mem_we=0, mem_tag=0, mem_wdata=0.
  - A reset mid-transaction aborts it: no response is issued and the pending request is discarded.
- Ages are always a permutation of {0,1,2,3}. 0 = most recently used, 3 = LRU.
- Age update on access to way w with old age a:
  - age[w] becomes 0.
  - Every way with age < a increments.
  - Ways with age > a are unchanged.
  - Applied exactly once per completed access (hit or fill), in the completing cycle.
- Victim selection: lowest-index invalid way if any; otherwise the way with age 3.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE:
  - req_ready=1 (combinational from state).
  - When req_valid=1, latch req_wr/req_tag/req_wdata and go to LOOKUP.
  - req_ready=0 in every other state; req_valid is ignored there.
- LOOKUP:
  - Hit = any valid way whose tag equals the latched tag (at most one can match).
  - Hit, read: update ages; resp_rdata<=data[w]; resp_hit<=1; go to RESP.
  - Hit, write: data[w]<=wdata; dirty[w]<=1; update ages; resp_rdata<=wdata; resp_hit<=1; go to RESP.
  - Miss: latch the victim index. If the victim is valid and dirty, go to WB; otherwise go to FILL.
- WB:
  - mem_req=1, mem_we=1, mem_tag=victim tag, mem_wdata=victim data, all held stable until mem_ack.
  - On mem_ack, go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_tag=latched tag, held stable until mem_ack.
  - On mem_ack: tag<=latched tag; valid<=1.
  - Read miss: data<=mem_rdata, dirty<=0.
  - Write miss: data<=req_wdata (mem_rdata discarded), dirty<=1.
  - Update ages for the victim; resp_rdata<=stored data; resp_hit<=0; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_hit hold until the next response.
- mem_ack is allowed in the first cycle of mem_req and is ignored outside WB/FILL. mem_req deasserts in the cycle after the ack.
- Latency, with acceptance at cycle 0:
  - Hit: resp_valid at cycle 2.
  - Clean miss with ack at cycle k: resp_valid at k+1.
  - Dirty miss: WB, then FILL, then RESP.
- Back-to-back requests: the next request can be accepted in the cycle after RESP, i.e. one request in flight at a time.

Test Plan:
- Reset, then read misses for tags 1,2,3,4 with mem_ack the same cycle, mem_rdata=0x11,0x22,0x33,0x44 -> four fills into ways 0..3, each resp_hit=0 with matching rdata; ages after each fill (0,1,2,3), (1,0,2,3), (2,1,0,3), (3,2,1,0); no writeback.
- Read tag 1 -> resp_valid 2 cycles after acceptance, resp_hit=1, rdata=0x11, mem_req never asserted, dbg_ages ages (0,3,2,1).
- Read tag 6, clean miss -> FILL only with mem_tag=6, way1 replaced, ages (1,0,3,2).
- Write hit tag 3 with 0x3C (ages (2,1,0,3)), then read misses 7, 8, 9, 10 -> evictions in order way3, way0, way1, way2. Tag 10 triggers WB with mem_we=1, mem_tag=3, mem_wdata=0x3C before the FILL with mem_tag=10.
- Miss with mem_ack delayed 5 cycles -> mem_req, mem_we and mem_tag stable throughout, req_ready=0, an extra req_valid pulse is ignored, exactly one resp_valid.
- Assert reset for one cycle during FILL -> mem_req=0 and req_ready=1 after that edge, no resp_valid, ages (0,1,2,3); a subsequent read of tag 1 misses.

Source files
------------

// File: rtl/lru_cache_ctrl.sv
// Access-side controller for one 4-way set with per-way 2-bit LRU ages.
// Resolves CPU hits and misses, writes back dirty victims and fills lines from memory.
module lru_cache_ctrl #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [TAG_W-1:0]  mem_tag,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        dbg_ages
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

  state_t state, state_next;

  logic [3:0]        valid;
  logic [3:0]        dirty;
  logic [TAG_W-1:0]  tags [4];
  logic [DATA_W-1:0] data [4];
  logic [1:0]        age  [4];

  logic              lat_wr;
  logic [TAG_W-1:0]  lat_tag;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        victim;

  logic       hit;
  logic [1:0] hit_way;
  logic [1:0] victim_sel;
  logic       access_en;
  logic [1:0] access_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (valid[i] && tags[i] == lat_tag) begin
        hit     = 1'b1;
        hit_way = 2'(i);
      end
    end
  end

  // Oldest way by default; a descending scan lets the lowest invalid way override it.
  always_comb begin
    victim_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (age[i] == 2'd3) victim_sel = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (!valid[i]) victim_sel = 2'(i);
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_tag    = '0;
    mem_wdata  = '0;
    access_en  = 1'b0;
    access_way = hit_way;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          access_en  = 1'b1;
          state_next = RESP;
        end else if (valid[victim_sel] && dirty[victim_sel]) begin
          state_next = WB;
        end else begin
          state_next = FILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_tag   = tags[victim];
        mem_wdata = data[victim];
        if (mem_ack) state_next = FILL;
      end
      FILL: begin
        mem_req    = 1'b1;
        mem_tag    = lat_tag;
        access_way = victim;
        if (mem_ack) begin
          access_en  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign dbg_ages   = {age[3], age[2], age[1], age[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      lat_wr     <= 1'b0;
      lat_tag    <= '0;
      lat_wdata  <= '0;
      victim     <= 2'd0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
      for (int i = 0; i < 4; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
        age[i]  <= 2'(i);
      end
    end else begin
      state <= state_next;

      if (state == IDLE && req_valid) begin
        lat_wr    <= req_wr;
        lat_tag   <= req_tag;
        lat_wdata <= req_wdata;
      end

      if (state == LOOKUP && !hit) victim <= victim_sel;

      // Touched way becomes youngest; only ways younger than it age by one.
      if (access_en) begin
        for (int i = 0; i < 4; i++) begin
          if (2'(i) == access_way) begin
            age[i] <= 2'd0;
          end else if (age[i] < age[access_way]) begin
            age[i] <= age[i] + 2'd1;
          end
        end
      end

      if (state == LOOKUP && hit) begin
        resp_hit <= 1'b1;
        if (lat_wr) begin
          data[hit_way]  <= lat_wdata;
          dirty[hit_way] <= 1'b1;
          resp_rdata     <= lat_wdata;
        end else begin
          resp_rdata <= data[hit_way];
        end
      end

      if (state == FILL && mem_ack) begin
        tags[victim]  <= lat_tag;
        valid[victim] <= 1'b1;
        resp_hit      <= 1'b0;
        if (lat_wr) begin
          data[victim]  <= lat_wdata;
          dirty[victim] <= 1'b1;
          resp_rdata    <= lat_wdata;
        end else begin
          data[victim]  <= mem_rdata;
          dirty[victim] <= 1'b0;
          resp_rdata    <= mem_rdata;
        end
      end
    end
  end

endmodule
